// File: rtl/seg7_pkg.sv
// Shared constants for the four-digit seven-segment scanner.
//   FONT_TAB : active-low g..a patterns for hex digits 0..F
//   AN_OFF   : all anodes disabled (active-low)
//   CX_OFF   : all segments and dp dark (active-low)
//   DP_OFF   : decimal-point bit value when the dp is dark
//   DIGITS   : number of multiplexed digits
package seg7_pkg;

    localparam int DIGITS = 4;

    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [7:0] CX_OFF = 8'hFF;
    localparam logic       DP_OFF = 1'b1;

    // Index = nibble value, bit 6 = g ... bit 0 = a, 0 = segment lit.
    localparam logic [6:0] FONT_TAB [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_font.sv
// Combinational hex-nibble to seven-segment decoder.
//   nibble : hex digit to render
//   seg    : active-low segment pattern, seg[6:0] = g..a
module seg7_font
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = FONT_TAB[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a 4-anode / 8-segment display.
// The shown value is snapshotted once per scan frame so a frame never mixes
// old and new digits, and every digit slot starts with a dark guard interval
// so the previous digit's segments cannot ghost onto the next anode.
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   value      : four hex nibbles, nibble k on digit k (digit 0 rightmost)
//   dp         : per-digit decimal-point request, active-high
//   blank_lz   : 1 = blank leading zero digits (digit 0 always shown)
//   AN         : registered anode enables, active-low
//   CX         : registered segments, active-low, CX[7] = dp, CX[6:0] = g..a
//   frame_tick : one-cycle pulse in the cycle after a snapshot is taken
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int GUARD = 1000,
    parameter int CNT_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       value,
    input  logic [DIGITS-1:0] dp,
    input  logic              blank_lz,
    output logic [3:0]        AN,
    output logic [7:0]        CX,
    output logic              frame_tick
);

    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        idx_r;
    logic [15:0]       shadow_value_r;
    logic [DIGITS-1:0] shadow_dp_r;
    logic              shadow_blz_r;
    logic [3:0]        an_r;
    logic [7:0]        cx_r;
    logic              frame_tick_r;

    logic              tick_s;
    logic              snap_s;
    logic [3:0]        nibble_s;
    logic              upper_zero_s;
    logic              blank_s;
    logic              dark_s;
    logic [6:0]        font_s;

    assign tick_s = (cnt_r == CNT_W'(DIV - 1));
    assign snap_s = tick_s && (idx_r == 2'd3);

    // Select the active nibble and decide whether it is a leading zero:
    // digit k is blanked only when nibbles k..3 are all zero.
    always_comb begin
        nibble_s     = 4'h0;
        upper_zero_s = 1'b0;
        case (idx_r)
            2'd0: begin
                nibble_s     = shadow_value_r[3:0];
                upper_zero_s = 1'b0;
            end
            2'd1: begin
                nibble_s     = shadow_value_r[7:4];
                upper_zero_s = (shadow_value_r[15:4] == 12'h000);
            end
            2'd2: begin
                nibble_s     = shadow_value_r[11:8];
                upper_zero_s = (shadow_value_r[15:8] == 8'h00);
            end
            2'd3: begin
                nibble_s     = shadow_value_r[15:12];
                upper_zero_s = (shadow_value_r[15:12] == 4'h0);
            end
            default: begin
                nibble_s     = 4'h0;
                upper_zero_s = 1'b0;
            end
        endcase
    end

    assign blank_s = shadow_blz_r && upper_zero_s;
    assign dark_s  = (cnt_r < CNT_W'(GUARD)) || blank_s;

    seg7_font u_font (
        .nibble (nibble_s),
        .seg    (font_s)
    );

    // Prescaler, digit index and once-per-frame input snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r          <= '0;
            idx_r          <= 2'd0;
            shadow_value_r <= 16'h0000;
            shadow_dp_r    <= '0;
            shadow_blz_r   <= 1'b0;
            frame_tick_r   <= 1'b0;
        end else begin
            if (tick_s) begin
                cnt_r <= '0;
                idx_r <= idx_r + 2'd1;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (snap_s) begin
                shadow_value_r <= value;
                shadow_dp_r    <= dp;
                shadow_blz_r   <= blank_lz;
            end
            frame_tick_r <= snap_s;
        end
    end

    // Registered anode/segment drive; one cycle behind the scan state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_r <= AN_OFF;
            cx_r <= CX_OFF;
        end else if (dark_s) begin
            an_r <= AN_OFF;
            cx_r <= CX_OFF;
        end else begin
            an_r <= ~(4'b0001 << idx_r);
            cx_r <= {(shadow_dp_r[idx_r] ? ~DP_OFF : DP_OFF), font_s};
        end
    end

    assign AN         = an_r;
    assign CX         = cx_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized self-checking bench for seg7_scan (DIV=8, GUARD=2).
// The reference model works from the elapsed cycle count since reset release:
// slot position and digit index are derived arithmetically, the snapshot is a
// copy of the inputs at every frame boundary, and segments come from a
// standalone hex font table.
module tb_seg7_scan;

    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int CNT_W = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank_lz;
    logic [3:0]  an;
    logic [7:0]  cx;
    logic        frame_tick;

    seg7_scan #(.DIV(DIV), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp         (dp),
        .blank_lz   (blank_lz),
        .AN         (an),
        .CX         (cx),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int          k;          // clock edges since reset release
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_blz;
    logic [3:0]  exp_an;
    logic [7:0]  exp_cx;
    logic        exp_ft;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] font8(input logic [3:0] n);
        case (n)
            4'h0: font8 = 8'hC0;  4'h1: font8 = 8'hF9;  4'h2: font8 = 8'hA4;  4'h3: font8 = 8'hB0;
            4'h4: font8 = 8'h99;  4'h5: font8 = 8'h92;  4'h6: font8 = 8'h82;  4'h7: font8 = 8'hF8;
            4'h8: font8 = 8'h80;  4'h9: font8 = 8'h90;  4'hA: font8 = 8'h88;  4'hB: font8 = 8'h83;
            4'hC: font8 = 8'hC6;  4'hD: font8 = 8'hA1;  4'hE: font8 = 8'h86;  default: font8 = 8'h8E;
        endcase
    endfunction

    task automatic model_reset();
        k      = 0;
        m_val  = 16'h0000;
        m_dp   = 4'h0;
        m_blz  = 1'b0;
        exp_an = 4'b1111;
        exp_cx = 8'hFF;
        exp_ft = 1'b0;
    endtask

    // Advance the model by one clock edge, using the scan position before it.
    task automatic model_edge();
        int          pos;
        int          idx;
        logic [15:0] upper;
        logic        blanked;
        pos     = k % DIV;
        idx     = (k / DIV) % 4;
        upper   = m_val >> (4 * idx);
        blanked = (idx != 0) && m_blz && (upper == 16'h0000);
        if (pos >= GUARD && !blanked) begin
            exp_an = ~(4'b0001 << idx);
            exp_cx = font8(m_val[4*idx +: 4]) & (m_dp[idx] ? 8'h7F : 8'hFF);
        end else begin
            exp_an = 4'b1111;
            exp_cx = 8'hFF;
        end
        exp_ft = (pos == DIV - 1) && (idx == 3);
        if (exp_ft) begin
            m_val = value;
            m_dp  = dp;
            m_blz = blank_lz;
        end
        k++;
    endtask

    // One clock: update model at the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("an", {12'h000, an}, {12'h000, exp_an});
        check("cx", {8'h00, cx}, {8'h00, exp_cx});
        check("frame_tick", {15'h0000, frame_tick}, {15'h0000, exp_ft});
        check("an_onehot", {15'h0000, ($countones(~an) <= 1)}, 16'h0001);
        check("dark_cx", {15'h0000, (an != 4'b1111 || cx == 8'hFF)}, 16'h0001);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset    = 1'b1;
        value    = 16'h0000;
        dp       = 4'h0;
        blank_lz = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_an", {12'h000, an}, 16'h000F);
        check("rst_cx", {8'h00, cx}, 16'h00FF);
        check("rst_ft", {15'h0000, frame_tick}, 16'h0000);
        reset = 1'b0;

        // Basic scan: frame 0 shows "0000", later frames show 1A80.
        value = 16'h1A80;
        run(3 * FRAME);

        // Snapshot stability: change mid-frame, only the next frame shows it.
        run(12);
        value = 16'hFFFF;
        run(2 * FRAME);

        // Decimal point on digit 2.
        value = 16'h0000;
        dp    = 4'b0100;
        run(2 * FRAME);

        // Leading-zero blanking.
        dp       = 4'b0000;
        blank_lz = 1'b1;
        value    = 16'h0005;
        run(2 * FRAME);
        value = 16'h0000;
        run(2 * FRAME);

        // Asynchronous reset in the middle of slot 2.
        value    = 16'h4321;
        blank_lz = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((k / DIV) % 4 == 2 && (k % DIV) == 4) break;
            step();
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_an", {12'h000, an}, 16'h000F);
        check("async_cx", {8'h00, cx}, 16'h00FF);
        check("async_ft", {15'h0000, frame_tick}, 16'h0000);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run(2 * FRAME);

        // Random inputs, changed at random cycles, biased toward leading zeros.
        for (int i = 0; i < 10 * FRAME; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                value    = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
                dp       = 4'($urandom);
                blank_lz = 1'($urandom);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
